// File: rtl/cpu_pkg.sv
// Shared CPU constants: default widths, fetch FSM encoding, opcode map.
package cpu_pkg;

    localparam int unsigned PC_W_DEF    = 8;
    localparam int unsigned INSTR_W_DEF = 16;
    localparam int unsigned OPCODE_W    = 4;
    localparam int unsigned NOP_WORD    = 0;

    localparam logic [OPCODE_W-1:0] OP_NOP  = 4'b0000;
    localparam logic [OPCODE_W-1:0] OP_ADD  = 4'b0001;
    localparam logic [OPCODE_W-1:0] OP_SUB  = 4'b0010;
    localparam logic [OPCODE_W-1:0] OP_AND  = 4'b0011;
    localparam logic [OPCODE_W-1:0] OP_OR   = 4'b0100;
    localparam logic [OPCODE_W-1:0] OP_LD   = 4'b0101;
    localparam logic [OPCODE_W-1:0] OP_ST   = 4'b0110;
    localparam logic [OPCODE_W-1:0] OP_JMP  = 4'b0111;
    localparam logic [OPCODE_W-1:0] OP_JAL  = 4'b1000;
    localparam logic [OPCODE_W-1:0] OP_BEQ  = 4'b1001;
    localparam logic [OPCODE_W-1:0] HALT_OP = 4'b1111;

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_HALTED = 1'b1
    } fetch_state_e;

endpackage

// File: rtl/pc_reg.sv
// Program counter with wrap-around incrementer; load beats hold beats increment.
module pc_reg #(
    parameter int unsigned     PC_W     = 8,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_load,
    input  logic            i_hold,
    input  logic [PC_W-1:0] i_target,
    output logic [PC_W-1:0] o_pc
);

    logic [PC_W-1:0] pc_q;
    logic [PC_W-1:0] pc_d;

    always_comb begin
        pc_d = pc_q;
        if (i_load) begin
            pc_d = i_target;
        end else if (!i_hold) begin
            pc_d = pc_q + PC_W'(1);
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign o_pc = pc_q;

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: PC sequencing, IF/ID register and RUN/HALTED control.
module instr_fetch
    import cpu_pkg::*;
#(
    parameter int unsigned     PC_W     = PC_W_DEF,
    parameter int unsigned     INSTR_W  = INSTR_W_DEF,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic               i_clk,
    input  logic               i_rst,
    output logic [PC_W-1:0]    o_imem_addr,
    input  logic [INSTR_W-1:0] i_imem_data,
    input  logic               i_stall,
    input  logic               i_jump,
    input  logic [PC_W-1:0]    i_jump_target,
    input  logic               i_flush,
    output logic [INSTR_W-1:0] o_instr,
    output logic [3:0]         o_opcode,
    output logic [PC_W-1:0]    o_pc,
    output logic [PC_W-1:0]    o_pc_plus1,
    output logic               o_valid
);

    fetch_state_e       state_q, state_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic [PC_W-1:0]    id_pc_q, id_pc_d;
    logic               valid_q, valid_d;
    logic               pc_load;
    logic               pc_hold;
    logic [PC_W-1:0]    pc;

    pc_reg #(
        .PC_W     (PC_W),
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_load   (pc_load),
        .i_hold   (pc_hold),
        .i_target (i_jump_target),
        .o_pc     (pc)
    );

    // Priority: jump > flush > stall > advance; the PC only moves on jump or a non-HALT advance.
    always_comb begin
        state_d = state_q;
        instr_d = instr_q;
        id_pc_d = id_pc_q;
        valid_d = valid_q;
        pc_load = 1'b0;
        pc_hold = 1'b1;
        if (i_jump) begin
            pc_load = 1'b1;
            instr_d = INSTR_W'(NOP_WORD);
            valid_d = 1'b0;
            state_d = ST_RUN;
        end else if (i_flush) begin
            instr_d = INSTR_W'(NOP_WORD);
            valid_d = 1'b0;
        end else if (!i_stall) begin
            case (state_q)
                ST_RUN: begin
                    instr_d = i_imem_data;
                    id_pc_d = pc;
                    valid_d = 1'b1;
                    if (i_imem_data[INSTR_W-1 -: 4] == HALT_OP) begin
                        state_d = ST_HALTED;
                    end else begin
                        pc_hold = 1'b0;
                    end
                end
                ST_HALTED: begin
                    instr_d = INSTR_W'(NOP_WORD);
                    valid_d = 1'b0;
                end
                default: state_d = ST_RUN;
            endcase
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= ST_RUN;
            instr_q <= INSTR_W'(NOP_WORD);
            id_pc_q <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            instr_q <= instr_d;
            id_pc_q <= id_pc_d;
            valid_q <= valid_d;
        end
    end

    assign o_imem_addr = pc;
    assign o_instr     = instr_q;
    assign o_opcode    = instr_q[INSTR_W-1 -: 4];
    assign o_pc        = id_pc_q;
    assign o_pc_plus1  = id_pc_q + PC_W'(1);
    assign o_valid     = valid_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch with a combinational instruction memory model.
module tb_instr_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  imem_addr;
    logic [15:0] imem_data;
    logic        stall;
    logic        jump;
    logic [7:0]  jump_target;
    logic        flush;
    logic [15:0] instr;
    logic [3:0]  opcode;
    logic [7:0]  pc;
    logic [7:0]  pc_plus1;
    logic        valid;

    logic [15:0] mem [256];
    int          total = 0;
    int          bad   = 0;

    always #5 clk = ~clk;

    assign imem_data = mem[imem_addr];

    instr_fetch dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .o_imem_addr   (imem_addr),
        .i_imem_data   (imem_data),
        .i_stall       (stall),
        .i_jump        (jump),
        .i_jump_target (jump_target),
        .i_flush       (flush),
        .o_instr       (instr),
        .o_opcode      (opcode),
        .o_pc          (pc),
        .o_pc_plus1    (pc_plus1),
        .o_valid       (valid)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_run(input string tag, input logic [7:0] epc);
        chk({tag, " pc"},     32'(pc),       32'(epc));
        chk({tag, " instr"},  32'(instr),    32'(16'h2000 + 16'(epc)));
        chk({tag, " valid"},  32'(valid),    32'(1'b1));
        chk({tag, " plus1"},  32'(pc_plus1), 32'(8'(epc + 8'd1)));
        chk({tag, " opcode"}, 32'(opcode),   32'(4'h2));
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, " valid"},  32'(valid),     32'(1'b0));
        chk({tag, " instr"},  32'(instr),     32'(16'h0000));
        chk({tag, " pc"},     32'(pc),        32'(8'h00));
        chk({tag, " plus1"},  32'(pc_plus1),  32'(8'h01));
        chk({tag, " opcode"}, 32'(opcode),    32'(4'h0));
        chk({tag, " addr"},   32'(imem_addr), 32'(8'h00));
    endtask

    task automatic chk_bubble(input string tag, input logic [7:0] eaddr);
        chk({tag, " valid"}, 32'(valid),     32'(1'b0));
        chk({tag, " instr"}, 32'(instr),     32'(16'h0000));
        chk({tag, " addr"},  32'(imem_addr), 32'(eaddr));
    endtask

    initial begin
        for (int k = 0; k < 256; k++) mem[k] = 16'h2000 + 16'(k);
        rst = 1'b1; stall = 1'b0; jump = 1'b0; flush = 1'b0; jump_target = 8'h00;
        repeat (2) step();
        chk_reset("reset");
        rst = 1'b0;

        // Sequential fetch from RESET_PC
        for (int k = 0; k < 6; k++) begin
            step();
            chk_run("seq", 8'(k));
        end

        // Stall three cycles at o_pc=5
        stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            chk_run("stall", 8'h05);
        end
        stall = 1'b0;
        step();
        chk_run("post_stall", 8'h06);

        // Jump with a simultaneous stall, then run through the wrap
        jump = 1'b1; jump_target = 8'hF0; stall = 1'b1;
        step();
        chk_bubble("jump", 8'hF0);
        jump = 1'b0; stall = 1'b0;
        for (int k = 16'hF0; k <= 16'hFF; k++) begin
            step();
            chk_run("jrun", 8'(k));
        end
        step();
        chk_run("wrap", 8'h00);

        // Flush at o_pc=3 replays address 4
        for (int k = 1; k <= 3; k++) begin
            step();
            chk_run("pre_flush", 8'(k));
        end
        flush = 1'b1;
        step();
        chk_bubble("flush", 8'h04);
        flush = 1'b0;
        step();
        chk_run("replay", 8'h04);
        step();
        chk_run("replay_next", 8'h05);

        // HALT at address 6
        mem[6] = 16'hF000;
        step();
        chk("halt pc",     32'(pc),        32'(8'h06));
        chk("halt instr",  32'(instr),     32'(16'hF000));
        chk("halt opcode", 32'(opcode),    32'(4'hF));
        chk("halt valid",  32'(valid),     32'(1'b1));
        chk("halt addr",   32'(imem_addr), 32'(8'h06));
        for (int k = 0; k < 3; k++) begin
            step();
            chk_bubble("halted", 8'h06);
        end
        flush = 1'b1;
        step();
        chk_bubble("halt_flush", 8'h06);
        flush = 1'b0;
        step();
        chk_bubble("still_halted", 8'h06);

        // Jump out of HALTED
        jump = 1'b1; jump_target = 8'h02;
        step();
        chk_bubble("halt_jump", 8'h02);
        jump = 1'b0;
        for (int k = 2; k <= 5; k++) begin
            step();
            chk_run("resume", 8'(k));
        end
        step();
        chk("rehalt opcode", 32'(opcode), 32'(4'hF));
        chk("rehalt valid",  32'(valid),  32'(1'b1));
        step();
        chk_bubble("rehalted", 8'h06);

        // Asynchronous reset mid-cycle while HALTED
        #3;
        rst = 1'b1;
        #1;
        chk_reset("async_rst");
        #2;
        rst = 1'b0;
        step();
        chk_run("restart", 8'h00);
        step();
        chk_run("restart_next", 8'h01);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 The block SHALL have parameter PC_W, default 8, program-counter and instruction-memory address width.
REQ-002 The block SHALL have parameter INSTR_W, default 16, instruction width, with opcode at bits [INSTR_W-1:INSTR_W-4].
REQ-003 The block SHALL have parameter RESET_PC, default 0, PC value loaded on reset.
REQ-004 i_clk  input  1  single clock; all state updates on rising edge.
REQ-005 i_rst  input  1  reset, asynchronous, active-high.
REQ-006 o_imem_addr  output  PC_W  instruction-memory address, equal to current PC.
REQ-007 i_imem_data  input  INSTR_W  instruction word at o_imem_addr, valid in the same cycle (combinational memory).
REQ-008 i_stall  input  1  hold PC and IF/ID register.
REQ-009 i_jump  input  1  redirect PC to i_jump_target and squash IF/ID.
REQ-010 i_jump_target  input  PC_W  redirect address, sampled when i_jump=1.
REQ-011 i_flush  input  1  squash IF/ID, hold PC (replay).
REQ-012 o_instr  output  INSTR_W  IF/ID instruction register.
REQ-013 o_opcode  output  4  o_instr[INSTR_W-1:INSTR_W-4], feeds the opcode decoder.
REQ-014 o_pc  output  PC_W  PC of the instruction held in IF/ID.
REQ-015 o_pc_plus1  output  PC_W  o_pc+1 mod 2^PC_W (link address for jump-and-link).
REQ-016 o_valid  output  1  IF/ID holds a real instruction; 0 = bubble.

Function
REQ-017 The block SHALL implement a two-state FSM: RUN and HALTED.
REQ-018 Edge priority SHALL be: reset > i_jump > i_flush > i_stall > normal advance.
REQ-019 Normal advance (RUN, no jump/flush/stall): IF/ID <= {i_imem_data, PC, valid=1}; PC <= PC+1; one-cycle fetch latency.
REQ-020 PC increment SHALL wrap 2^PC_W-1 -> 0 with no flag.
REQ-021 i_jump=1: PC <= i_jump_target; o_instr <= 0, o_valid <= 0; state <= RUN; i_stall and i_flush ignored that cycle.
REQ-022 i_flush=1, i_jump=0: o_instr <= 0, o_valid <= 0; PC unchanged; state unchanged; i_stall ignored.
REQ-023 i_stall=1 (no jump/flush): PC, IF/ID, state all hold.
REQ-024 In RUN, advancing a word whose opcode is HALT_OP (4'b1111) SHALL load it into IF/ID with valid=1, hold PC at the HALT address, and go to HALTED.
REQ-025 In HALTED without jump/flush/stall: o_instr <= 0, o_valid <= 0, PC holds.
REQ-026 HALTED SHALL be exited only by i_jump or reset; i_flush in HALTED squashes IF/ID and stays HALTED.
REQ-027 o_opcode and o_pc_plus1 SHALL be purely combinational from IF/ID contents.

Reset
REQ-028 On i_rst=1, asynchronously: PC=RESET_PC, o_instr=0, o_pc=0, o_valid=0, state=RUN; o_pc_plus1=1, o_opcode=0 follow.
REQ-029 Reset asserted mid-operation (including HALTED or during stall) SHALL override all inputs immediately.
REQ-030 The first edge after reset release SHALL fetch RESET_PC (o_valid=1 one cycle after release, absent stall).

Structure
REQ-031 PC_W/INSTR_W defaults, HALT_OP, NOP word (0) and FSM state encoding SHALL live in shared package cpu_pkg, which also holds the decoder's opcode constants.
REQ-032 The PC register and incrementer SHALL be a sub-module pc_reg (inputs load, hold, target); IF/ID register and FSM stay in instr_fetch.

Verification
REQ-033 Reset, release, memory word at addr k = 16'h2000+k, no stall -> o_pc 0,1,2,... with o_instr 16'h2000,16'h2001,..., o_valid=1 from the first edge.
REQ-034 i_stall high for 3 cycles at o_pc=5 -> o_pc=5, o_instr unchanged for 3 cycles, then o_pc=6.
REQ-035 i_jump=1, target 8'hF0, with i_stall=1 in the same cycle -> next cycle o_valid=0, o_instr=0; following cycle o_pc=8'hF0; run continues to 8'hFF then o_pc=8'h00 (wrap).
REQ-036 i_flush at o_pc=3 (PC=4) -> bubble one cycle, then o_pc=4 (replay), no skipped address.
REQ-037 HALT word 16'hF000 at addr 6 -> o_opcode=4'hF, o_valid=1 once, then o_valid=0 indefinitely with o_imem_addr=6; i_flush keeps halted; i_jump target 2 -> o_pc=2 valid two cycles later.
REQ-038 i_rst pulsed mid-cycle while HALTED -> outputs at reset values before next edge; fetch restarts at RESET_PC.
